// File: rtl/button_debounce_reader_if.sv
// Signal bundle between a debounced pushbutton reader and the fabric logic that consumes it.
// Latency: none, wires only.
// Backpressure: none. Events are strobes and the consumer must take them when they occur.
interface button_debounce_reader_if;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  // The reader side takes the raw pad and drives the clean outputs.
  modport master (
    input  btn_in,
    output btn_level, press_pulse, release_pulse, long_pulse, press_count
  );

  // The consumer side drives the pad (board or bench) and observes the outputs.
  modport slave (
    output btn_in,
    input  btn_level, press_pulse, release_pulse, long_pulse, press_count
  );
endinterface

// File: rtl/button_debounce_reader.sv
// Debounces a raw pushbutton pad into a level, press/release/long strobes and a press counter.
// Latency: a stable pad change is reported DEBOUNCE_CYCLES+3 clock edges after it is first sampled.
// Backpressure: none. Outputs are registered strobes. BTN_LONG_PRESS_EN enables the long-press detector.
module button_debounce_reader #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int CNT_W           = 24,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  button_debounce_reader_if.master  btn
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  // Raw pad value that means "released"; the synchronizer resets to it.
  localparam logic             REL_RAW = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter sets the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1 ||
      longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W) ||
      longint'(LONG_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_param
    $error("button_debounce_reader: unsupported parameter combination");
  end

  logic             sync1, sync2, s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic [7:0]       count_q, count_d;

  // Two-flop synchronizer for the asynchronous pad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= REL_RAW;
      sync2 <= REL_RAW;
    end else begin
      sync1 <= btn.btn_in;
      sync2 <= sync1;
    end
  end

  // Normalise polarity so that s=1 always means pressed.
  assign s = sync2 ^ REL_RAW;

  // Debounce FSM: next state, counter and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
          count_d = count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, debounce counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      count_q <= count_d;
    end
  end

  assign btn.btn_level     = level_q;
  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = rel_q;
  assign btn.press_count   = count_q;

`ifdef BTN_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);

  logic [CNT_W-1:0] hold_q, hold_d;
  logic             long_q, long_d;

  // Hold counter: runs while the button is accepted as pressed, saturates after one long strobe.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (state_q == PRESS_WAIT) begin
      hold_d = '0;
    end else if (state_q == PRESSED || state_q == RELEASE_WAIT) begin
      // An accepted release wins; the long strobe never shares a cycle with it.
      if (state_d == IDLE) begin
        hold_d = '0;
      end else if (hold_q == LONG_LAST) begin
        long_d = 1'b1;
        hold_d = LONG_SAT;
      end else if (hold_q < LONG_LAST) begin
        hold_d = hold_q + 1'b1;
      end
    end else begin
      hold_d = '0;
    end
  end

  // Hold counter and long strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign btn.long_pulse = long_q;
`else
  assign btn.long_pulse = 1'b0;
`endif

endmodule

// File: doc/button_debounce_reader.md
Name: button_debounce_reader

Overview:
- Input-side counterpart to the board LED drivers: samples a raw pushbutton pad and produces clean, debounced level and event outputs for fabric logic.
- Runs on the single fabric clock taken from the cell macro's C16 clock.
- Chain per button: 2-flop synchronizer, debounce FSM with cycle counter, one-cycle press/release event pulses, wrapping press counter.
- Optional long-press detector.

Parameters:
- DEBOUNCE_CYCLES, 240000, number of consecutive stable synchronized samples required to accept a transition. Minimum 2.
- LONG_CYCLES, 12000000, number of held cycles in PRESSED before long_pulse fires. Used only with the long-press feature.
- CNT_W, 24, width of the debounce and hold counters. Must hold max(DEBOUNCE_CYCLES, LONG_CYCLES).
- ACTIVE_LOW, 1, 1 = pad reads 0 when pressed. The raw input is inverted after the synchronizer when this is set.

Ports:
- clk, input, 1, fabric clock (C16).
- rst_n, input, 1, asynchronous active-low reset.
- btn_in, input, 1, raw asynchronous button pad.
- btn_level, output, 1, debounced state; 1 = pressed.
- press_pulse, output, 1, one-cycle strobe on accepted press.
- release_pulse, output, 1, one-cycle strobe on accepted release.
- long_pulse, output, 1, one-cycle strobe when the long-hold threshold is reached.
- press_count, output, 8, number of accepted presses; wraps.

Behaviour:
Reset:
- Asserting rst_n low asynchronously clears all of the following:
  - synchronizer flops, to the "released" value after polarity normalisation;
  - FSM, to IDLE;
  - counters, to 0;
  - outputs: btn_level=0, press_pulse=0, release_pulse=0, long_pulse=0, press_count=0.
- All outputs are registered.
- Deassertion mid-press: a button still held is handled as a fresh press, i.e. full debounce, then press_pulse.

Synchronizer:
- btn_in passes through 2 flops, then is normalised by ACTIVE_LOW to s (1 = pressed).

FSM states and transitions:
- IDLE:
  - s=1 -> PRESS_WAIT, counter=0.
- PRESS_WAIT:
  - s=0 -> IDLE, counter=0. No output change.
  - s=1 and counter==DEBOUNCE_CYCLES-1 -> PRESSED. Set btn_level=1, press_pulse=1 for one cycle, press_count+1.
  - otherwise counter+1.
- PRESSED:
  - s=0 -> RELEASE_WAIT, counter=0.
- RELEASE_WAIT:
  - s=1 -> PRESSED, counter=0. No pulse; btn_level stays 1.
  - s=0 and counter==DEBOUNCE_CYCLES-1 -> IDLE. Set btn_level=0, release_pulse=1 for one cycle.
  - otherwise counter+1.

Timing:
- A raw pad transition held stable is reported DEBOUNCE_CYCLES+3 clock edges after the first edge that samples it:
  - 2 edges through the synchronizer;
  - 1 edge to enter the wait state;
  - DEBOUNCE_CYCLES edges of counting.
- Any glitch shorter than DEBOUNCE_CYCLES+1 synchronized cycles produces no output change.

Boundary conditions:
- press_pulse and release_pulse are never high in the same cycle.
- Minimum spacing between a press_pulse and the following release_pulse is DEBOUNCE_CYCLES+1 cycles.
- press_count wraps 255 -> 0 with no flag.
- The debounce counter never exceeds DEBOUNCE_CYCLES-1.

Optional Feature:
- Macro: BTN_LONG_PRESS_EN.

With the macro defined:
- A hold counter runs only in PRESSED and RELEASE_WAIT. It clears on entry to PRESSED from PRESS_WAIT.
- RELEASE_WAIT->PRESSED bounces do not clear the hold counter.
- When the hold counter == LONG_CYCLES-1, long_pulse is high for one cycle and the counter saturates. long_pulse fires at most once per accepted press.
- The hold counter is cleared in IDLE.
- long_pulse may coincide with neither press_pulse nor release_pulse.

Without the macro:
- No hold counter is instantiated and long_pulse is tied to 0.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, LONG_CYCLES=32, ACTIVE_LOW=1.
1. Reset: hold rst_n=0 with btn_in=0 (pressed) -> all outputs 0 during reset. After release, press_pulse fires 11 edges later, btn_level=1, press_count=1.
2. Glitch rejection: btn_in low for 5 cycles, then high -> no pulses, btn_level stays 0, press_count stays 0.
3. Bounce then clean press: btn_in toggles every 3 cycles ×4, then held low -> exactly one press_pulse, 11 edges after the final stable low edge.
4. Release bounce: while pressed, btn_in high for 4 cycles, low again, later high stable -> no release_pulse on the bounce. Exactly one release_pulse after stable high; btn_level goes 0 in the same cycle.
5. Counter wrap: 256 clean press/release cycles -> press_count reads 0 after the 256th press_pulse, 255 before it.
6. Long press (BTN_LONG_PRESS_EN defined): hold pressed for 60 cycles past press_pulse -> a single long_pulse 32 cycles after press_pulse, none afterwards. With the macro undefined, long_pulse stays 0 throughout.
